// File: rtl/aes_gf_pkg.sv
// GF(2^8) helpers shared by the MixColumns datapath: the AES reduction polynomial,
// mode encodings, circulant coefficient rows and constant multipliers.
package aes_gf_pkg;

  localparam logic [7:0]  AES_POLY = 8'h1B;
  localparam logic        MODE_FWD = 1'b0;
  localparam logic        MODE_INV = 1'b1;

  // Circulant first rows, coefficient for offset 0 in the top byte.
  localparam logic [31:0] FWD_ROW  = 32'h02030101;
  localparam logic [31:0] INV_ROW  = 32'h0E0B0D09;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] gmul_01(input logic [7:0] b);
    return b;
  endfunction

  function automatic logic [7:0] gmul_02(input logic [7:0] b);
    return xtime(b);
  endfunction

  function automatic logic [7:0] gmul_03(input logic [7:0] b);
    return xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] gmul_09(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic logic [7:0] gmul_0b(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] gmul_0d(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic logic [7:0] gmul_0e(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

  function automatic logic [7:0] gmul_const(input logic [7:0] b, input logic [7:0] c);
    case (c)
      8'h01:   return gmul_01(b);
      8'h02:   return gmul_02(b);
      8'h03:   return gmul_03(b);
      8'h09:   return gmul_09(b);
      8'h0B:   return gmul_0b(b);
      8'h0D:   return gmul_0d(b);
      8'h0E:   return gmul_0e(b);
      default: return 8'h00;
    endcase
  endfunction

  // Coefficient M[r][j] of a circulant matrix depends only on (j - r) mod 4.
  function automatic logic [7:0] row_coef(input logic mode, input logic [1:0] offset);
    logic [31:0] row;
    row = (mode == MODE_INV) ? INV_ROW : FWD_ROW;
    return row[8*(3 - int'(offset)) +: 8];
  endfunction

endpackage

// File: rtl/gf_col_contrib.sv
// Contribution of one input byte (row j) to all four output rows of a MixColumns column.
module gf_col_contrib
  import aes_gf_pkg::*;
(
  input  logic [7:0]  data_byte,
  input  logic [1:0]  row_idx,
  input  logic        mode,
  output logic [31:0] contrib
);

  // NOTE: every variable written in always_comb gets a value before any branch;
  // a path that leaves it unassigned would infer a latch.
  always_comb begin
    contrib = '0;
    for (int r = 0; r < 4; r++) begin
      contrib[8*(3-r) +: 8] = gmul_const(data_byte, row_coef(mode, row_idx - 2'(r)));
    end
  end

endmodule

// File: rtl/mix_columns_stream.sv
// Streaming MixColumns / InvMixColumns: LANES bytes per beat in, one column accumulated
// while the previous result drains from a separate buffer, valid/ready on both sides.
module mix_columns_stream
  import aes_gf_pkg::*;
#(
  parameter int LANES          = 1,
  parameter bit RESET_OUT_ZERO = 1'b1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [8*LANES-1:0] in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_mode,
  output logic [8*LANES-1:0] out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_mode,
  output logic               out_last
);

  localparam int         BEATS     = 4 / LANES;
  localparam int         DW        = 8 * LANES;
  localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

  logic [1:0]  cnt_q, cnt_d;
  logic        mode_q, mode_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] buf_q, buf_d;
  logic        buf_mode_q, buf_mode_d;
  logic        buf_valid_q, buf_valid_d;
  logic [1:0]  out_idx_q, out_idx_d;

  logic        col_mode;
  logic        in_fire, out_fire;
  logic        last_in_beat, last_out_beat;
  logic [31:0] lane_contrib [LANES];
  logic [31:0] beat_contrib;
  logic [31:0] acc_sum;
  logic [31:0] buf_shifted;

  // The first beat of a column supplies its own mode; later beats use the latched copy.
  assign col_mode = (cnt_q == 2'd0) ? in_mode : mode_q;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [1:0] row_j;
    assign row_j = 2'(int'(cnt_q) * LANES + l);

    gf_col_contrib u_contrib (
      .data_byte (in_data[DW-1-8*l -: 8]),
      .row_idx   (row_j),
      .mode      (col_mode),
      .contrib   (lane_contrib[l])
    );
  end

  always_comb begin
    beat_contrib = '0;
    for (int l = 0; l < LANES; l++) begin
      beat_contrib = beat_contrib ^ lane_contrib[l];
    end
  end

  assign last_in_beat  = (cnt_q == LAST_BEAT);
  assign last_out_beat = (out_idx_q == LAST_BEAT);
  assign out_valid     = buf_valid_q;
  assign out_last      = buf_valid_q && last_out_beat;
  assign out_mode      = buf_mode_q;

  // Only a column's final beat needs the buffer; it may enter as the last result beat leaves.
  assign in_ready = !last_in_beat || !buf_valid_q || (buf_valid_q && last_out_beat && out_ready);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = buf_valid_q && out_ready;

  assign acc_sum = ((cnt_q == 2'd0) ? 32'h0 : acc_q) ^ beat_contrib;

  always_comb begin
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    acc_d       = acc_q;
    buf_d       = buf_q;
    buf_mode_d  = buf_mode_q;
    buf_valid_d = buf_valid_q;
    out_idx_d   = out_idx_q;

    if (in_fire) begin
      acc_d = acc_sum;
      cnt_d = last_in_beat ? 2'd0 : cnt_q + 2'd1;
      if (cnt_q == 2'd0) begin
        mode_d = in_mode;
      end
    end

    if (out_fire) begin
      if (last_out_beat) begin
        buf_valid_d = 1'b0;
        out_idx_d   = 2'd0;
      end else begin
        out_idx_d   = out_idx_q + 2'd1;
      end
    end

    // A completing column wins over a draining one, giving the seamless reload.
    if (in_fire && last_in_beat) begin
      buf_d       = acc_sum;
      buf_mode_d  = col_mode;
      buf_valid_d = 1'b1;
      out_idx_d   = 2'd0;
    end
  end

  always_comb begin
    buf_shifted = buf_q << (DW * int'(out_idx_q));
    out_data    = buf_shifted[31 -: DW];
    if (RESET_OUT_ZERO && !buf_valid_q) begin
      out_data = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values; blocking here would create order-dependent simulation races.
  // NOTE: the accumulators and result buffer are ordinary flops, not RAM, so they
  // are cleared by reset along with the control state.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q       <= 2'd0;
      mode_q      <= MODE_FWD;
      acc_q       <= '0;
      buf_q       <= '0;
      buf_mode_q  <= MODE_FWD;
      buf_valid_q <= 1'b0;
      out_idx_q   <= 2'd0;
    end else begin
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      acc_q       <= acc_d;
      buf_q       <= buf_d;
      buf_mode_q  <= buf_mode_d;
      buf_valid_q <= buf_valid_d;
      out_idx_q   <= out_idx_d;
    end
  end

endmodule
